// File: rtl/cpu4_pkg.sv
// cpu4_pkg: shared encodings for the 4-bit accumulator CPU and its run controller.
package cpu4_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_e;
  localparam logic [3:0] OP_JMP = 4'b1111;
  function automatic logic [3:0] op_f(input logic [7:0] w);
    return w[7:4];
  endfunction
  function automatic logic [3:0] im_f(input logic [7:0] w);
    return w[3:0];
  endfunction
endpackage

// File: rtl/cycle_watchdog.sv
// cycle_watchdog: saturating executed-instruction counter with clear, enable and limit-hit flag.
module cycle_watchdog #(
  parameter int CW  = 8,
  parameter int MAX = 255
) (
  input  logic          ck_i,
  input  logic          nrst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          hit_o
);
  localparam logic [CW-1:0] LIM = CW'(MAX);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat;
  assign sat   = cnt_q == LIM;
  assign cnt_o = cnt_q;
  // hit fires on the enabled cycle whose increment lands exactly on the limit
  assign hit_o = en_i && !clr_i && (cnt_q == LIM - ONE);
  always_comb cnt_d = clr_i ? '0 : (en_i && !sat) ? cnt_q + ONE : cnt_q;
  always_ff @(posedge ck_i) begin
    if (!nrst_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: program loader and RUN/STEP clock-enable sequencer with self-jump halt and watchdog.
module cpu_run_controller
  import cpu4_pkg::*;
#(
  parameter int CW         = 8,
  parameter int MAX_CYCLES = 255
) (
  input  logic          ck_i,
  input  logic          nrst_i,
  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  logic [3:0]    ld_addr_i,
  input  logic [7:0]    ld_data_i,
  input  logic          ld_last_i,
  input  logic          cmd_run_i,
  input  logic          cmd_step_i,
  input  logic          cmd_halt_i,
  input  logic          cmd_load_i,
  input  logic [3:0]    pc_i,
  input  logic [7:0]    op_im_i,
  output logic          ram_we_o,
  output logic [3:0]    ram_waddr_o,
  output logic [7:0]    ram_wdata_o,
  output logic          cpu_en_o,
  output logic          cpu_rst_n_o,
  output logic [2:0]    state_o,
  output logic          halted_o,
  output logic          timeout_o,
  output logic [CW-1:0] cycles_o
);
  state_e state_q, state_d;
  logic   halted_q, halted_d, timeout_q, timeout_d, cpu_rst_n_q, cpu_rst_n_d;
  logic   xfer, self_jmp, idle_or_halt, load_go, blocked, wd_hit;

  assign ld_ready_o   = state_q == ST_LOAD;
  assign xfer         = ld_ready_o && ld_valid_i;
  assign ram_we_o     = xfer;
  assign ram_waddr_o  = ld_addr_i;
  assign ram_wdata_o  = ld_data_i;
  assign cpu_en_o     = state_q == ST_STEP || (state_q == ST_RUN && !cmd_halt_i);
  assign idle_or_halt = state_q == ST_IDLE || state_q == ST_HALT;
  assign load_go      = idle_or_halt && cmd_load_i;
  assign blocked      = halted_q || timeout_q;
  // detected even when a simultaneous CMD_HALT masks the enable, so HALTED still wins
  assign self_jmp     = (state_q == ST_RUN || state_q == ST_STEP) &&
                        op_f(op_im_i) == OP_JMP && im_f(op_im_i) == pc_i;

  cycle_watchdog #(.CW(CW), .MAX(MAX_CYCLES)) u_wd (
    .ck_i  (ck_i),
    .nrst_i(nrst_i),
    .clr_i (load_go),
    .en_i  (cpu_en_o),
    .cnt_o (cycles_o),
    .hit_o (wd_hit)
  );

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q | self_jmp;
    timeout_d = timeout_q | wd_hit;
    if (load_go) begin
      state_d   = ST_LOAD;
      halted_d  = 1'b0;
      timeout_d = 1'b0;
    end else if (state_q == ST_LOAD) begin
      state_d = (xfer && ld_last_i) ? ST_IDLE : ST_LOAD;
    end else if (state_q == ST_RUN) begin
      state_d = (self_jmp || cmd_halt_i || wd_hit) ? ST_HALT : ST_RUN;
    end else if (state_q == ST_STEP) begin
      state_d = ST_HALT;
    end else if (idle_or_halt && !cmd_halt_i && !blocked) begin
      state_d = cmd_step_i ? ST_STEP : cmd_run_i ? ST_RUN : state_q;
    end
    cpu_rst_n_d = state_d == ST_RUN || state_d == ST_STEP || state_d == ST_HALT;
  end

  always_ff @(posedge ck_i) begin
    if (!nrst_i) begin
      state_q     <= ST_IDLE;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign state_o     = state_q;
  assign halted_o    = halted_q;
  assign timeout_o   = timeout_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: controller with a behavioural PC/RAM stand-in, checked against a program-trace model.
module tb_cpu_run_controller;
  localparam int CW   = 8;
  localparam int MAXC = 20;

  logic clk = 1'b0, nrst = 1'b0;
  logic ld_valid = 1'b0, ld_last = 1'b0;
  logic cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0, cmd_load = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [3:0] pc;
  logic [7:0] op_im;
  logic ld_ready, ram_we, cpu_en, cpu_rst_n, halted, timeout;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [2:0] state;
  logic [CW-1:0] cycles;
  logic [7:0] ram [16];
  logic [7:0] prog [16];
  int n_cmp = 0, n_fail = 0;

  cpu_run_controller #(.CW(CW), .MAX_CYCLES(MAXC)) dut (
    .ck_i(clk), .nrst_i(nrst), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .cmd_run_i(cmd_run), .cmd_step_i(cmd_step), .cmd_halt_i(cmd_halt), .cmd_load_i(cmd_load),
    .pc_i(pc), .op_im_i(op_im), .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
    .cpu_en_o(cpu_en), .cpu_rst_n_o(cpu_rst_n), .state_o(state), .halted_o(halted),
    .timeout_o(timeout), .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) ram[i] = 8'h00;
  always @(posedge clk) if (ram_we) ram[ram_waddr] <= ram_wdata;
  assign op_im = ram[pc];
  always @(posedge clk) begin
    if (!cpu_rst_n) pc <= 4'd0;
    else if (cpu_en) pc <= (op_im[7:4] == 4'hF) ? op_im[3:0] : pc + 4'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walk the program from address 0 and count instructions until a self-jump or the watchdog limit.
  task automatic model(output int cnt, output logic h, output logic t, output logic [3:0] fpc);
    logic [3:0] p;
    p = 4'd0; cnt = 0; h = 1'b0; t = 1'b0;
    while (!h && !t) begin
      cnt++;
      if (prog[p][7:4] == 4'hF && prog[p][3:0] == p) h = 1'b1;
      p = (prog[p][7:4] == 4'hF) ? prog[p][3:0] : p + 4'd1;
      if (cnt == MAXC) t = 1'b1;
    end
    fpc = p;
  endtask

  task automatic load_prog(input int n);
    cmd_load = 1'b1; tick; cmd_load = 1'b0;
    n_cmp++;
    if ({state, ld_ready} !== {3'd1, 1'b1}) begin
      n_fail++; $display("FAIL load_entry: state/ready=%b want 0011", {state, ld_ready});
    end
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_addr = i[3:0]; ld_data = prog[i]; ld_last = (i == n - 1);
      #1;
      n_cmp++;
      if ({ram_we, ram_waddr, ram_wdata} !== {1'b1, ld_addr, ld_data}) begin
        n_fail++; $display("FAIL load_write[%0d]: got %h want %h", i, {ram_we, ram_waddr, ram_wdata}, {1'b1, ld_addr, ld_data});
      end
      tick;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_cmp++;
    if ({state, cycles, halted, timeout, cpu_rst_n} !== {3'd0, 8'd0, 3'b000}) begin
      n_fail++; $display("FAIL load_exit: st=%0d cyc=%0d h=%b t=%b rstn=%b want 0 0 0 0 0", state, cycles, halted, timeout, cpu_rst_n);
    end
  endtask

  task automatic run_to_stop;
    int k;
    cmd_run = 1'b1; tick; cmd_run = 1'b0;
    k = 0;
    while (state == 3'd2 && k < 200) begin tick; k++; end
    n_cmp++;
    if (k >= 200) begin n_fail++; $display("FAIL run_bound: still running after %0d cycles, want stop", k); end
  endtask

  task automatic check_stop(input string nm);
    int cnt; logic h, t; logic [3:0] fpc;
    model(cnt, h, t, fpc);
    n_cmp++;
    if ({state, cycles, halted, timeout, pc} !== {3'd4, 8'(cnt), h, t, fpc}) begin
      n_fail++;
      $display("FAIL %s: st=%0d cyc=%0d h=%b t=%b pc=%0d want st=4 cyc=%0d h=%b t=%b pc=%0d",
               nm, state, cycles, halted, timeout, pc, cnt, h, t, fpc);
    end
  endtask

  task automatic set_case1;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h90; prog[1] = 8'h61; prog[2] = 8'hB0; prog[3] = 8'hF3;
  endtask

  task automatic test_reset;
    nrst = 1'b0; tick; tick;
    n_cmp++;
    if ({state, ld_ready, ram_we, cpu_en, cpu_rst_n, halted, timeout, cycles} !== {3'd0, 6'b0, 8'd0}) begin
      n_fail++; $display("FAIL reset: st=%0d rdy=%b we=%b en=%b rstn=%b h=%b t=%b cyc=%0d want all 0",
                         state, ld_ready, ram_we, cpu_en, cpu_rst_n, halted, timeout, cycles);
    end
    nrst = 1'b1; tick;
  endtask

  task automatic test_load_gate;
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if ({ld_ready, ram_we} !== 2'b00) begin
        n_fail++; $display("FAIL idle_gate: ready/we=%b want 00", {ld_ready, ram_we});
      end
    end
    ld_valid = 1'b0;
    set_case1;
    load_prog(4);
    n_cmp++;
    if ({ram[0], ram[1], ram[2], ram[3], ram[5]} !== {8'h90, 8'h61, 8'hB0, 8'hF3, 8'h00}) begin
      n_fail++; $display("FAIL ram_contents: got %h want 9061b0f300", {ram[0], ram[1], ram[2], ram[3], ram[5]});
    end
  endtask

  task automatic test_run;
    run_to_stop;
    check_stop("run_case1");
    n_cmp++;
    if ({cycles, halted, pc} !== {8'd4, 1'b1, 4'd3}) begin
      n_fail++; $display("FAIL run_const: cyc=%0d h=%b pc=%0d want 4 1 3", cycles, halted, pc);
    end
    cmd_run = 1'b1; tick; cmd_step = 1'b1; cmd_run = 1'b0; tick; cmd_step = 1'b0; tick;
    n_cmp++;
    if ({state, cycles} !== {3'd4, 8'd4}) begin
      n_fail++; $display("FAIL halted_blocks: st=%0d cyc=%0d want 4 4", state, cycles);
    end
  endtask

  task automatic test_step;
    logic [3:0] exp_pc [4];
    exp_pc[0] = 4'd1; exp_pc[1] = 4'd2; exp_pc[2] = 4'd3; exp_pc[3] = 4'd3;
    set_case1;
    load_prog(4);
    for (int k = 0; k < 4; k++) begin
      cmd_step = 1'b1; tick; cmd_step = 1'b0;
      n_cmp++;
      if ({state, cpu_en} !== {3'd3, 1'b1}) begin
        n_fail++; $display("FAIL step_en[%0d]: st=%0d en=%b want 3 1", k, state, cpu_en);
      end
      tick;
      n_cmp++;
      if ({state, cycles, pc, halted} !== {3'd4, 8'(k + 1), exp_pc[k], k == 3}) begin
        n_fail++; $display("FAIL step[%0d]: st=%0d cyc=%0d pc=%0d h=%b want 4 %0d %0d %b",
                           k, state, cycles, pc, halted, k + 1, exp_pc[k], k == 3);
      end
    end
    cmd_step = 1'b1; tick; cmd_step = 1'b0; tick;
    n_cmp++;
    if ({state, cycles} !== {3'd4, 8'd4}) begin
      n_fail++; $display("FAIL step_blocked: st=%0d cyc=%0d want 4 4", state, cycles);
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h01; prog[1] = 8'hF0;
    load_prog(2);
    run_to_stop;
    check_stop("timeout");
    n_cmp++;
    if ({timeout, halted, cycles} !== {2'b10, 8'(MAXC)}) begin
      n_fail++; $display("FAIL timeout_const: t=%b h=%b cyc=%0d want 1 0 %0d", timeout, halted, cycles, MAXC);
    end
    cmd_run = 1'b1; tick; cmd_run = 1'b0; tick;
    n_cmp++;
    if ({state, cycles} !== {3'd4, 8'(MAXC)}) begin
      n_fail++; $display("FAIL timeout_blocks: st=%0d cyc=%0d want 4 %0d", state, cycles, MAXC);
    end
  endtask

  task automatic test_halt_resume;
    set_case1;
    load_prog(4);
    cmd_run = 1'b1; tick; cmd_run = 1'b0; tick; tick;
    cmd_halt = 1'b1; #1;
    n_cmp++;
    if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL halt_en: en=%b want 0", cpu_en); end
    tick; cmd_halt = 1'b0;
    n_cmp++;
    if ({state, cycles, pc} !== {3'd4, 8'd2, 4'd2}) begin
      n_fail++; $display("FAIL halt_state: st=%0d cyc=%0d pc=%0d want 4 2 2", state, cycles, pc);
    end
    tick; tick; tick;
    n_cmp++;
    if ({cpu_en, cycles, pc, cpu_rst_n} !== {1'b0, 8'd2, 4'd2, 1'b1}) begin
      n_fail++; $display("FAIL halt_frozen: en=%b cyc=%0d pc=%0d rstn=%b want 0 2 2 1", cpu_en, cycles, pc, cpu_rst_n);
    end
    run_to_stop;
    check_stop("halt_resume");
  endtask

  task automatic test_reset_mid;
    cmd_load = 1'b1; tick; cmd_load = 1'b0; tick;
    nrst = 1'b0; tick; nrst = 1'b1;
    n_cmp++;
    if ({state, ld_ready, cpu_rst_n, cycles} !== {3'd0, 2'b00, 8'd0}) begin
      n_fail++; $display("FAIL reset_mid_load: st=%0d rdy=%b rstn=%b cyc=%0d want 0 0 0 0", state, ld_ready, cpu_rst_n, cycles);
    end
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h01; prog[1] = 8'hF0;
    load_prog(2);
    cmd_run = 1'b1; tick; cmd_run = 1'b0;
    repeat (5) tick;
    nrst = 1'b0; tick; nrst = 1'b1;
    n_cmp++;
    if ({state, cpu_rst_n, cpu_en, cycles, halted, timeout} !== {3'd0, 2'b00, 8'd0, 2'b00}) begin
      n_fail++; $display("FAIL reset_mid_run: st=%0d rstn=%b en=%b cyc=%0d h=%b t=%b want all 0",
                         state, cpu_rst_n, cpu_en, cycles, halted, timeout);
    end
    n_cmp++;
    if ({ram[0], ram[1]} !== 16'h01F0) begin
      n_fail++; $display("FAIL ram_retained: got %h want 01f0", {ram[0], ram[1]});
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++)
        prog[i] = {($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      if (r % 2 == 0) begin
        automatic int a = $urandom_range(0, 15);
        prog[a] = {4'hF, 4'(a)};
      end
      load_prog(16);
      run_to_stop;
      check_stop($sformatf("random[%0d]", r));
    end
  endtask

  initial begin
    test_reset;
    test_load_gate;
    test_run;
    test_step;
    test_timeout;
    test_halt_resume;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
